age_ordered_rs: RTL and testbench

Parametrised reservation station for the out-of-order core: holds dispatched ALU ops until operands arrive over any of `NUM_CDB` result buses, then issues the oldest ready entry to the ALU through a registered valid/ready port. Successor to the fixed 16-entry, 2-CDB station. Adds configurable depth, tag width and bus count, age-ordered issue, backpressure from the ALU, a real `full` signal and dispatch-time CDB capture.

---
 rtl/age_ordered_rs.sv | 228 ++++++++++++++++++++++
 tb/tb_age_ordered_rs.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/age_ordered_rs.sv
// Reservation station: holds dispatched ALU ops until their operands arrive on the
// result buses, then issues the oldest ready entry through a registered valid/ready port.
module age_ordered_rs #(
  parameter int DEPTH   = 16,
  parameter int TAG_W   = 4,
  parameter int NUM_CDB = 2,
  parameter int OP_W    = 6,
  parameter int XLEN    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rdy,
  input  logic                     clear,
  input  logic                     disp_valid,
  input  logic [OP_W-1:0]          disp_op,
  input  logic [XLEN-1:0]          disp_vj,
  input  logic [XLEN-1:0]          disp_vk,
  input  logic                     disp_qj_v,
  input  logic                     disp_qk_v,
  input  logic [TAG_W-1:0]         disp_qj,
  input  logic [TAG_W-1:0]         disp_qk,
  input  logic [XLEN-1:0]          disp_imm,
  input  logic [TAG_W-1:0]         disp_rob,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  input  logic [NUM_CDB-1:0]       cdb_ok,
  input  logic [NUM_CDB*TAG_W-1:0] cdb_tag,
  input  logic [NUM_CDB*XLEN-1:0]  cdb_val,
  output logic                     alu_valid,
  input  logic                     alu_ready,
  output logic [OP_W-1:0]          alu_op,
  output logic [XLEN-1:0]          alu_rs1,
  output logic [XLEN-1:0]          alu_rs2,
  output logic [XLEN-1:0]          alu_imm,
  output logic [TAG_W-1:0]         alu_rob
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] qj_v;
  logic [DEPTH-1:0] qk_v;
  logic [OP_W-1:0]  op_q  [DEPTH];
  logic [XLEN-1:0]  vj_q  [DEPTH];
  logic [XLEN-1:0]  vk_q  [DEPTH];
  logic [XLEN-1:0]  imm_q [DEPTH];
  logic [TAG_W-1:0] qj_q  [DEPTH];
  logic [TAG_W-1:0] qk_q  [DEPTH];
  logic [TAG_W-1:0] rob_q [DEPTH];
  // older[j][i] set means entry j was dispatched before entry i
  logic [DEPTH-1:0] older [DEPTH];

  logic [TAG_W-1:0] bus_tag [NUM_CDB];
  logic [XLEN-1:0]  bus_val [NUM_CDB];

  logic [DEPTH-1:0] wj_hit;
  logic [DEPTH-1:0] wk_hit;
  logic [XLEN-1:0]  wj_val [DEPTH];
  logic [XLEN-1:0]  wk_val [DEPTH];
  logic             dj_hit;
  logic             dk_hit;
  logic [XLEN-1:0]  dj_val;
  logic [XLEN-1:0]  dk_val;

  logic [DEPTH-1:0] ready;
  logic [DEPTH-1:0] blocked;
  logic [DEPTH-1:0] sel;
  logic             sel_any;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] free_idx;
  logic             accept;
  logic             take;

  always_comb begin
    for (int k = 0; k < NUM_CDB; k++) begin
      bus_tag[k] = cdb_tag[k*TAG_W +: TAG_W];
      bus_val[k] = cdb_val[k*XLEN +: XLEN];
    end
  end

  // Buses are scanned from the highest index down so the lowest matching bus wins.
  always_comb begin
    wj_hit = '0;
    wk_hit = '0;
    dj_hit = 1'b0;
    dk_hit = 1'b0;
    dj_val = '0;
    dk_val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wj_val[i] = '0;
      wk_val[i] = '0;
    end
    for (int k = NUM_CDB - 1; k >= 0; k--) begin
      if (cdb_ok[k]) begin
        if (disp_qj_v && disp_qj == bus_tag[k]) begin
          dj_hit = 1'b1;
          dj_val = bus_val[k];
        end
        if (disp_qk_v && disp_qk == bus_tag[k]) begin
          dk_hit = 1'b1;
          dk_val = bus_val[k];
        end
        for (int i = 0; i < DEPTH; i++) begin
          if (busy[i] && qj_v[i] && qj_q[i] == bus_tag[k]) begin
            wj_hit[i] = 1'b1;
            wj_val[i] = bus_val[k];
          end
          if (busy[i] && qk_v[i] && qk_q[i] == bus_tag[k]) begin
            wk_hit[i] = 1'b1;
            wk_val[i] = bus_val[k];
          end
        end
      end
    end
  end

  assign ready = busy & ~qj_v & ~qk_v;

  always_comb begin
    blocked = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (ready[j] && older[j][i]) blocked[i] = 1'b1;
      end
    end
  end

  assign sel     = ready & ~blocked;
  assign sel_any = |sel;

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel[i]) sel_idx = IDX_W'(i);
    end
  end

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy[i]) free_idx = IDX_W'(i);
    end
  end

  always_comb begin
    count = '0;
    for (int i = 0; i < DEPTH; i++) count = count + CNT_W'(busy[i]);
  end

  assign full   = &busy;
  assign accept = rdy && !clear && disp_valid && !full;
  assign take   = rdy && !clear && (!alu_valid || alu_ready) && sel_any;

  // A freed slot only becomes visible to free_idx next cycle, so dispatch and
  // issue never target the same entry in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
      qj_v <= '0;
      qk_v <= '0;
      for (int i = 0; i < DEPTH; i++) older[i] <= '0;
    end else if (rdy) begin
      if (clear) begin
        busy <= '0;
        for (int i = 0; i < DEPTH; i++) older[i] <= '0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (wj_hit[i]) qj_v[i] <= 1'b0;
          if (wk_hit[i]) qk_v[i] <= 1'b0;
        end
        if (take) busy[sel_idx] <= 1'b0;
        if (accept) begin
          busy[free_idx] <= 1'b1;
          qj_v[free_idx] <= disp_qj_v && !dj_hit;
          qk_v[free_idx] <= disp_qk_v && !dk_hit;
          for (int j = 0; j < DEPTH; j++) older[j][free_idx] <= busy[j];
          older[free_idx] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rdy && !clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wj_hit[i]) vj_q[i] <= wj_val[i];
        if (wk_hit[i]) vk_q[i] <= wk_val[i];
      end
      if (accept) begin
        op_q[free_idx]  <= disp_op;
        vj_q[free_idx]  <= dj_hit ? dj_val : disp_vj;
        vk_q[free_idx]  <= dk_hit ? dk_val : disp_vk;
        qj_q[free_idx]  <= disp_qj;
        qk_q[free_idx]  <= disp_qk;
        imm_q[free_idx] <= disp_imm;
        rob_q[free_idx] <= disp_rob;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_valid <= 1'b0;
      alu_op    <= '0;
      alu_rs1   <= '0;
      alu_rs2   <= '0;
      alu_imm   <= '0;
      alu_rob   <= '0;
    end else if (rdy) begin
      if (clear) begin
        alu_valid <= 1'b0;
      end else if (!alu_valid || alu_ready) begin
        alu_valid <= sel_any;
        if (sel_any) begin
          alu_op  <= op_q[sel_idx];
          alu_rs1 <= vj_q[sel_idx];
          alu_rs2 <= vk_q[sel_idx];
          alu_imm <= imm_q[sel_idx];
          alu_rob <= rob_q[sel_idx];
        end
      end
    end
  end

  sel_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(sel));

endmodule

// File: tb/tb_age_ordered_rs.sv
// Testbench for age_ordered_rs: directed scenarios plus randomized traffic, checked
// by a queue-based reference model feeding an issue scoreboard.
module tb_age_ordered_rs;

  localparam int DEPTH   = 16;
  localparam int TAG_W   = 4;
  localparam int NUM_CDB = 2;
  localparam int OP_W    = 6;
  localparam int XLEN    = 32;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     rdy = 1'b1;
  logic                     clear = 1'b0;
  logic                     disp_valid = 1'b0;
  logic [OP_W-1:0]          disp_op = '0;
  logic [XLEN-1:0]          disp_vj = '0;
  logic [XLEN-1:0]          disp_vk = '0;
  logic                     disp_qj_v = 1'b0;
  logic                     disp_qk_v = 1'b0;
  logic [TAG_W-1:0]         disp_qj = '0;
  logic [TAG_W-1:0]         disp_qk = '0;
  logic [XLEN-1:0]          disp_imm = '0;
  logic [TAG_W-1:0]         disp_rob = '0;
  logic                     full;
  logic [$clog2(DEPTH):0]   count;
  logic [NUM_CDB-1:0]       cdb_ok = '0;
  logic [NUM_CDB*TAG_W-1:0] cdb_tag = '0;
  logic [NUM_CDB*XLEN-1:0]  cdb_val = '0;
  logic                     alu_valid;
  logic                     alu_ready = 1'b1;
  logic [OP_W-1:0]          alu_op;
  logic [XLEN-1:0]          alu_rs1;
  logic [XLEN-1:0]          alu_rs2;
  logic [XLEN-1:0]          alu_imm;
  logic [TAG_W-1:0]         alu_rob;

  age_ordered_rs #(
    .DEPTH(DEPTH), .TAG_W(TAG_W), .NUM_CDB(NUM_CDB), .OP_W(OP_W), .XLEN(XLEN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .clear(clear),
    .disp_valid(disp_valid), .disp_op(disp_op), .disp_vj(disp_vj), .disp_vk(disp_vk),
    .disp_qj_v(disp_qj_v), .disp_qk_v(disp_qk_v), .disp_qj(disp_qj), .disp_qk(disp_qk),
    .disp_imm(disp_imm), .disp_rob(disp_rob), .full(full), .count(count),
    .cdb_ok(cdb_ok), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_op(alu_op),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_imm(alu_imm), .alu_rob(alu_rob)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [XLEN-1:0]  vj;
    logic [XLEN-1:0]  vk;
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] rob;
    logic             qj_v;
    logic             qk_v;
    logic [TAG_W-1:0] qj;
    logic [TAG_W-1:0] qk;
  } ent_t;

  // Model: entries kept oldest-first; exp_q holds what the ALU port should present.
  ent_t rs_model[$];
  ent_t exp_q[$];
  bit   model_valid = 1'b0;
  int   checks = 0;
  int   errors = 0;

  task automatic check_output(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic bit bus_lookup(input logic [TAG_W-1:0] tag, output logic [XLEN-1:0] val);
    val = '0;
    for (int k = 0; k < NUM_CDB; k++) begin
      if (cdb_ok[k] && cdb_tag[k*TAG_W +: TAG_W] == tag) begin
        val = cdb_val[k*XLEN +: XLEN];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic model_step();
    bit               was_full;
    int               pick;
    ent_t             e;
    logic [XLEN-1:0]  v;
    was_full = (rs_model.size() == DEPTH);
    if (!model_valid || alu_ready) begin
      pick = -1;
      foreach (rs_model[i]) begin
        if (pick < 0 && !rs_model[i].qj_v && !rs_model[i].qk_v) pick = i;
      end
      if (pick >= 0) begin
        exp_q.push_back(rs_model[pick]);
        rs_model.delete(pick);
        model_valid = 1'b1;
      end else begin
        model_valid = 1'b0;
      end
    end
    foreach (rs_model[i]) begin
      if (rs_model[i].qj_v && bus_lookup(rs_model[i].qj, v)) begin
        rs_model[i].qj_v = 1'b0;
        rs_model[i].vj   = v;
      end
      if (rs_model[i].qk_v && bus_lookup(rs_model[i].qk, v)) begin
        rs_model[i].qk_v = 1'b0;
        rs_model[i].vk   = v;
      end
    end
    if (disp_valid && !was_full) begin
      e.op  = disp_op;
      e.imm = disp_imm;
      e.rob = disp_rob;
      e.qj  = disp_qj;
      e.qk  = disp_qk;
      e.qj_v = disp_qj_v;
      e.vj   = disp_vj;
      e.qk_v = disp_qk_v;
      e.vk   = disp_vk;
      if (disp_qj_v && bus_lookup(disp_qj, v)) begin
        e.qj_v = 1'b0;
        e.vj   = v;
      end
      if (disp_qk_v && bus_lookup(disp_qk, v)) begin
        e.qk_v = 1'b0;
        e.vk   = v;
      end
      rs_model.push_back(e);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_model.delete();
      exp_q.delete();
      model_valid = 1'b0;
    end else if (rdy) begin
      if (clear) begin
        rs_model.delete();
        exp_q.delete();
        model_valid = 1'b0;
      end else begin
        model_step();
      end
    end
  end

  // Monitor: occupancy every cycle, and an issue compare on every accepted handshake.
  always @(negedge clk) begin
    ent_t e;
    if (rst_n) begin
      check_output("count", count, rs_model.size());
      check_output("full", full, rs_model.size() == DEPTH);
      check_output("alu_valid", alu_valid, model_valid);
      if (alu_valid && alu_ready && rdy && !clear) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL issue_unexpected actual rob=%0h expected no issue at %0t", alu_rob, $time);
        end else begin
          e = exp_q.pop_front();
          check_output("issue", {alu_op, alu_rs1, alu_rs2, alu_imm, alu_rob},
                       {e.op, e.vj, e.vk, e.imm, e.rob});
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    disp_valid = 1'b0;
    cdb_ok     = '0;
    clear      = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [OP_W-1:0] op, input logic [XLEN-1:0] vj,
                                input logic [XLEN-1:0] vk, input logic qjv,
                                input logic [TAG_W-1:0] qj, input logic qkv,
                                input logic [TAG_W-1:0] qk, input logic [XLEN-1:0] imm,
                                input logic [TAG_W-1:0] rob);
    disp_valid = 1'b1;
    disp_op    = op;
    disp_vj    = vj;
    disp_vk    = vk;
    disp_qj_v  = qjv;
    disp_qj    = qj;
    disp_qk_v  = qkv;
    disp_qk    = qk;
    disp_imm   = imm;
    disp_rob   = rob;
  endtask

  task automatic broadcast(input int bus, input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] val);
    cdb_ok[bus]                  = 1'b1;
    cdb_tag[bus*TAG_W +: TAG_W]  = tag;
    cdb_val[bus*XLEN +: XLEN]    = val;
  endtask

  initial begin
    idle();
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_valid", alu_valid, 0);
    check_output("reset_count", count, 0);
    check_output("reset_full", full, 0);
    check_output("reset_data", {alu_op, alu_rs1, alu_rs2, alu_imm, alu_rob}, 0);
    rst_n = 1'b1;
    tick();

    // Minimum-latency issue of a fully ready op.
    apply_stimulus(6'h01, 32'd5, 32'd7, 0, 0, 0, 0, 32'h100, 4'd1);
    tick(); idle();
    check_output("t1_count_c1", count, 1);
    check_output("t1_valid_c1", alu_valid, 0);
    tick();
    check_output("t1_valid_c2", alu_valid, 1);
    check_output("t1_rs1", alu_rs1, 5);
    check_output("t1_rs2", alu_rs2, 7);
    tick();
    check_output("t1_count_c3", count, 0);
    repeat (2) tick();

    // Younger ready entry overtakes an older pending one.
    apply_stimulus(6'h02, 32'd0, 32'd3, 1, 4'd3, 0, 0, 32'hA, 4'hA);
    tick();
    apply_stimulus(6'h03, 32'd8, 32'd9, 0, 0, 0, 0, 32'hB, 4'hB);
    tick(); idle();
    broadcast(0, 4'd3, 32'h10);
    tick(); idle();
    check_output("t2_first_rob", alu_rob, 4'hB);
    tick();
    check_output("t2_second_rob", alu_rob, 4'hA);
    check_output("t2_second_rs1", alu_rs1, 32'h10);
    repeat (3) tick();

    // Simultaneous wakeup: age order decides.
    for (int e = 0; e < 4; e++) begin
      if (e % 2 == 0) apply_stimulus(OP_W'(4 + e), 32'd0, XLEN'(e), 1, 4'd9, 0, 0, XLEN'(e), TAG_W'(e + 1));
      else            apply_stimulus(OP_W'(4 + e), XLEN'(e), 32'd0, 0, 0, 1, 4'd9, XLEN'(e), TAG_W'(e + 1));
      tick();
    end
    idle();
    broadcast(1, 4'd9, 32'h99);
    tick(); idle();
    for (int e = 0; e < 4; e++) begin
      tick();
      check_output("t3_order_rob", alu_rob, TAG_W'(e + 1));
    end
    repeat (3) tick();

    // Fill with the ALU stalled, drop an overflow dispatch, then release.
    alu_ready = 1'b0;
    for (int i = 0; i <= DEPTH; i++) begin
      apply_stimulus(6'h10, XLEN'(i), XLEN'(i + 100), 0, 0, 0, 0, XLEN'(i), TAG_W'(i));
      tick();
    end
    idle();
    check_output("t4_full", full, 1);
    check_output("t4_count", count, DEPTH);
    $display("[TB] note: dispatching while full (protocol violation, must be dropped)");
    apply_stimulus(6'h3F, 32'hDEAD, 32'hBEEF, 0, 0, 0, 0, 32'hDEAD, 4'hF);
    tick(); idle();
    check_output("t4_drop_count", count, DEPTH);
    alu_ready = 1'b1;
    tick();
    check_output("t4_full_fall", full, 0);
    check_output("t4_count_fall", count, DEPTH - 1);
    repeat (DEPTH + 3) tick();
    check_output("t4_drained", count, 0);

    // Operand captured from the bus in the dispatch cycle.
    apply_stimulus(6'h07, 32'h11, 32'd0, 0, 0, 1, 4'd5, 32'h5, 4'd5);
    broadcast(0, 4'd5, 32'hAB);
    tick(); idle();
    tick();
    check_output("t5_valid", alu_valid, 1);
    check_output("t5_rs2", alu_rs2, 32'hAB);
    repeat (3) tick();

    // Flush with busy entries and a held output.
    alu_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(6'h08, XLEN'(32'h50 + i), 32'd1, 0, 0, 0, 0, 32'd0, TAG_W'(i));
      tick();
    end
    idle();
    check_output("t6_pre_count", count, 3);
    check_output("t6_pre_valid", alu_valid, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_output("t6_clear_valid", alu_valid, 0);
    check_output("t6_clear_count", count, 0);

    // Asynchronous reset between edges.
    apply_stimulus(6'h09, 32'h77, 32'd2, 0, 0, 0, 0, 32'd3, 4'd7);
    tick();
    apply_stimulus(6'h09, 32'h78, 32'd2, 0, 0, 0, 0, 32'd3, 4'd8);
    tick(); idle();
    tick();
    check_output("t6_pre_rs1", alu_rs1, 32'h77);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("t6_arst_valid", alu_valid, 0);
    check_output("t6_arst_count", count, 0);
    check_output("t6_arst_full", full, 0);
    check_output("t6_arst_data", {alu_op, alu_rs1, alu_rs2, alu_imm, alu_rob}, 0);
    tick();
    rst_n = 1'b1;
    alu_ready = 1'b1;
    tick();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      idle();
      rdy       = ($urandom_range(0, 9) != 0);
      alu_ready = ($urandom_range(0, 3) != 0);
      clear     = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 2) != 0 && rs_model.size() < DEPTH) begin
        apply_stimulus(OP_W'($urandom), $urandom, $urandom,
                       ($urandom_range(0, 2) == 0), TAG_W'($urandom),
                       ($urandom_range(0, 2) == 0), TAG_W'($urandom),
                       $urandom, TAG_W'($urandom));
      end
      for (int k = 0; k < NUM_CDB; k++) begin
        if ($urandom_range(0, 1) != 0) broadcast(k, TAG_W'($urandom), $urandom);
      end
      tick();
    end

    // Drain by broadcasting every tag.
    idle();
    rdy = 1'b1;
    alu_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      idle();
      broadcast(0, TAG_W'(c), XLEN'(c * 3));
      broadcast(1, TAG_W'(c + 8), XLEN'(c * 5));
      tick();
    end
    idle();
    repeat (4) tick();
    check_output("final_count", count, 0);
    check_output("final_valid", alu_valid, 0);
    check_output("final_scoreboard", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
